issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised centralised issue queue that sits between rename/dispatch and the execution units. It holds up to DEPTH renamed micro-ops and tracks source-operand readiness through a tag-broadcast wakeup bus. Each cycle it selects, per issue port, the oldest ready micro-op of that port's functional-unit class, and presents it on a registered issue interface. It generalises the fixed 16-entry, four-arbiter issue stage with configurable depth, port count, port classes and wakeup width, and adds dispatch backpressure, flush and per-port FU stall.

## Interface
- DEPTH, 16, number of queue entries (≥2).
- PRF_WIDTH, 6, physical register tag width.
- OPCODE_WIDTH, 7, opcode width.
- AGE_WIDTH, 5, per-entry saturating age counter width.
- NUM_PORTS, 4, issue ports.
- PORT_CLASS, {2'd2,2'd1,2'd0,2'd0}, 2 bits per port (port p at [2p+1:2p]); classes: 0=ALU, 1=MUL, 2=LS.
- NUM_WAKEUP, 2, wakeup broadcast channels.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries and in-flight issue outputs.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept; high iff at least one entry is free (registered state).
- disp_op  in  OPCODE_WIDTH  opcode.
- disp_class  in  2  FU class.
- disp_prs1, disp_prs2  in  PRF_WIDTH each  source tags.
- disp_prs1_rdy, disp_prs2_rdy  in  1 each  source already available.
- disp_prd  in  PRF_WIDTH  destination tag; disp_prdv  in  1  destination valid.
- wk_valid  in  NUM_WAKEUP  wakeup strobes; wk_tag  in  NUM_WAKEUP*PRF_WIDTH  broadcast tags.
- fu_ready  in  NUM_PORTS  port p may receive a micro-op at the next edge.
- iss_valid  out  NUM_PORTS; iss_op  out  NUM_PORTS*OPCODE_WIDTH; iss_prs1, iss_prs2, iss_prd  out  NUM_PORTS*PRF_WIDTH each; iss_prdv  out  NUM_PORTS.

## Operation
- Entry state: valid, class, op, prs1/rdy, prs2/rdy, prd/prdv, age.
- Dispatch: on disp_valid & disp_ready, write the lowest-index free entry; age=0. A ready bit is set if the input ready is high or a same-cycle wakeup tag matches that source.
- Wakeup: for every valid entry, a source whose tag equals any wk_tag with wk_valid set has its rdy bit set at the edge. Tags are compared irrespective of class.
- Age: each valid entry increments age every cycle, saturating at 2^AGE_WIDTH−1.
- Eligible(e,p): valid, both rdy bits set (from registered state), class == PORT_CLASS[p], fu_ready[p], and e not selected by any port q<p.
- Select (combinational, per port in ascending order): the eligible entry with the largest age; ties go to the lowest index.
- At the edge: the selected entry is copied to port p's iss_* registers with iss_valid[p]=1 and the entry is freed. A port with no selection drives iss_valid[p]=0.
- Flush: at the edge, all entries are invalidated and all iss_valid are cleared. Flush has priority over same-cycle dispatch, wakeup and select; disp_ready is unaffected until the next cycle.
- Reset: all entries invalid, all ages 0, every iss_* output 0, disp_ready=1 after reset.

## Timing
- Dispatch in cycle N: the entry is selectable in N+1, giving the earliest iss_valid in N+2.
- Wakeup in cycle N: the waiting entry is selectable in N+1, giving iss_valid in N+2.
- Issue outputs are registered, one cycle after select. iss_valid is a single-cycle pulse per micro-op; there is no hold.
- Full: disp_ready=0 when all DEPTH entries are valid. Same-cycle frees do not raise disp_ready until the next cycle.
- An entry freed and the same slot redispatched take effect at the following edge, never the same one.
- Age saturation: ties among saturated entries resolve to the lowest index.
- fu_ready[p]=0 blocks only port p. Other same-class ports may still take the oldest entry.
- Reset asserted mid-operation clears state immediately (asynchronous), regardless of clk.

## Test plan
- Reset then dispatch an ALU op (op=7'h13, prs1=3, prs2=4, both rdy, prd=9) in cycle 0 → iss_valid[0]=1 in cycle 2 with iss_prd=9; port 1 stays idle.
- Dispatch an op with prs1=5 not ready, then wk_valid[0]=1, wk_tag=5 three cycles later → issues exactly 2 cycles after the wakeup, not before.
- Dispatch two ready ALU ops A then B, one cycle apart → A on port 0 and B on port 1 in the same cycle; swap to fu_ready=4'b1110 → A on port 1, B issues one cycle later on port 1.
- Fill all 16 entries with MUL ops not ready → disp_ready=0; wake one → it issues on port 2, and disp_ready returns to 1 one cycle after the free.
- Dispatch a source whose tag matches a same-cycle wakeup → the entry is ready and issues 2 cycles later.
- With 5 valid entries, assert flush alongside disp_valid → next cycle all entries are empty, iss_valid=0 and disp_ready=1; the flushed-cycle dispatch is dropped.

Source files
------------

// File: rtl/issue_queue.sv
// Centralised issue queue: holds renamed micro-ops, tracks source readiness via a
// tag-broadcast wakeup bus and issues the oldest ready op per port into registered outputs.
module issue_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PRF_WIDTH    = 6,
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned AGE_WIDTH    = 5,
  parameter int unsigned NUM_PORTS    = 4,
  parameter logic [2*NUM_PORTS-1:0] PORT_CLASS = {2'd2, 2'd1, 2'd0, 2'd0},
  parameter int unsigned NUM_WAKEUP   = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_flush,
  input  logic                              i_disp_valid,
  output logic                              o_disp_ready,
  input  logic [OPCODE_WIDTH-1:0]           i_disp_op,
  input  logic [1:0]                        i_disp_class,
  input  logic [PRF_WIDTH-1:0]              i_disp_prs1,
  input  logic [PRF_WIDTH-1:0]              i_disp_prs2,
  input  logic                              i_disp_prs1_rdy,
  input  logic                              i_disp_prs2_rdy,
  input  logic [PRF_WIDTH-1:0]              i_disp_prd,
  input  logic                              i_disp_prdv,
  input  logic [NUM_WAKEUP-1:0]             i_wk_valid,
  input  logic [NUM_WAKEUP*PRF_WIDTH-1:0]   i_wk_tag,
  input  logic [NUM_PORTS-1:0]              i_fu_ready,
  output logic [NUM_PORTS-1:0]              o_iss_valid,
  output logic [NUM_PORTS*OPCODE_WIDTH-1:0] o_iss_op,
  output logic [NUM_PORTS*PRF_WIDTH-1:0]    o_iss_prs1,
  output logic [NUM_PORTS*PRF_WIDTH-1:0]    o_iss_prs2,
  output logic [NUM_PORTS*PRF_WIDTH-1:0]    o_iss_prd,
  output logic [NUM_PORTS-1:0]              o_iss_prdv
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AGE_WIDTH-1:0] AgeMax = {AGE_WIDTH{1'b1}};

  // Entry storage
  logic [DEPTH-1:0]        r_valid;
  logic [DEPTH-1:0]        r_rdy1;
  logic [DEPTH-1:0]        r_rdy2;
  logic [DEPTH-1:0]        r_prdv;
  logic [1:0]              r_class [DEPTH];
  logic [OPCODE_WIDTH-1:0] r_op    [DEPTH];
  logic [PRF_WIDTH-1:0]    r_prs1  [DEPTH];
  logic [PRF_WIDTH-1:0]    r_prs2  [DEPTH];
  logic [PRF_WIDTH-1:0]    r_prd   [DEPTH];
  logic [AGE_WIDTH-1:0]    r_age   [DEPTH];

  // Registered issue interface
  logic [NUM_PORTS-1:0]              r_iss_valid;
  logic [NUM_PORTS*OPCODE_WIDTH-1:0] r_iss_op;
  logic [NUM_PORTS*PRF_WIDTH-1:0]    r_iss_prs1;
  logic [NUM_PORTS*PRF_WIDTH-1:0]    r_iss_prs2;
  logic [NUM_PORTS*PRF_WIDTH-1:0]    r_iss_prd;
  logic [NUM_PORTS-1:0]              r_iss_prdv;

  // Combinational control
  logic [DEPTH-1:0]     w_wake1;
  logic [DEPTH-1:0]     w_wake2;
  logic [DEPTH-1:0]     w_issue_clr;
  logic                 w_disp_wake1;
  logic                 w_disp_wake2;
  logic                 w_disp_fire;
  logic [IdxW-1:0]      w_free_idx;
  logic [NUM_PORTS-1:0] w_sel_vld;
  logic [IdxW-1:0]      w_sel_idx [NUM_PORTS];

  // Readiness comes from registered occupancy only, so same-cycle frees do not count.
  assign o_disp_ready = ~&r_valid;
  assign w_disp_fire  = i_disp_valid & o_disp_ready;

  assign o_iss_valid = r_iss_valid;
  assign o_iss_op    = r_iss_op;
  assign o_iss_prs1  = r_iss_prs1;
  assign o_iss_prs2  = r_iss_prs2;
  assign o_iss_prd   = r_iss_prd;
  assign o_iss_prdv  = r_iss_prdv;

  // Tag match of every wakeup channel against stored and dispatching sources.
  always_comb begin
    w_wake1      = '0;
    w_wake2      = '0;
    w_disp_wake1 = 1'b0;
    w_disp_wake2 = 1'b0;
    for (int w = 0; w < NUM_WAKEUP; w++) begin
      if (i_wk_valid[w]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (r_prs1[e] == i_wk_tag[w*PRF_WIDTH +: PRF_WIDTH]) w_wake1[e] = 1'b1;
          if (r_prs2[e] == i_wk_tag[w*PRF_WIDTH +: PRF_WIDTH]) w_wake2[e] = 1'b1;
        end
        if (i_disp_prs1 == i_wk_tag[w*PRF_WIDTH +: PRF_WIDTH]) w_disp_wake1 = 1'b1;
        if (i_disp_prs2 == i_wk_tag[w*PRF_WIDTH +: PRF_WIDTH]) w_disp_wake2 = 1'b1;
      end
    end
  end

  // Lowest-index free slot for dispatch.
  always_comb begin
    logic v_found;
    v_found    = 1'b0;
    w_free_idx = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!r_valid[e] && !v_found) begin
        v_found    = 1'b1;
        w_free_idx = IdxW'(e);
      end
    end
  end

  // Per-port oldest-ready select; lower ports claim entries first, ties go to lowest index.
  always_comb begin
    logic [DEPTH-1:0]     v_taken;
    logic [AGE_WIDTH-1:0] v_best;
    v_taken   = '0;
    v_best    = '0;
    w_sel_vld = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_sel_idx[p] = '0;
      v_best       = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (r_valid[e] && r_rdy1[e] && r_rdy2[e] && i_fu_ready[p] && !v_taken[e] &&
            (r_class[e] == PORT_CLASS[2*p +: 2])) begin
          if (!w_sel_vld[p] || (r_age[e] > v_best)) begin
            w_sel_vld[p] = 1'b1;
            w_sel_idx[p] = IdxW'(e);
            v_best       = r_age[e];
          end
        end
      end
      if (w_sel_vld[p]) v_taken[w_sel_idx[p]] = 1'b1;
    end
    w_issue_clr = v_taken;
  end

  // Entry state: flush beats issue-free, wakeup, aging and dispatch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      r_prdv  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_class[e] <= '0;
        r_op[e]    <= '0;
        r_prs1[e]  <= '0;
        r_prs2[e]  <= '0;
        r_prd[e]   <= '0;
        r_age[e]   <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
      for (int e = 0; e < DEPTH; e++) r_age[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (r_valid[e]) begin
          if (w_issue_clr[e]) begin
            r_valid[e] <= 1'b0;
            r_age[e]   <= '0;
          end else begin
            if (r_age[e] != AgeMax) r_age[e] <= r_age[e] + 1'b1;
            if (w_wake1[e]) r_rdy1[e] <= 1'b1;
            if (w_wake2[e]) r_rdy2[e] <= 1'b1;
          end
        end
      end
      // Target slot is free in registered state, so it never collides with the loop above.
      if (w_disp_fire) begin
        r_valid[w_free_idx] <= 1'b1;
        r_class[w_free_idx] <= i_disp_class;
        r_op[w_free_idx]    <= i_disp_op;
        r_prs1[w_free_idx]  <= i_disp_prs1;
        r_prs2[w_free_idx]  <= i_disp_prs2;
        r_rdy1[w_free_idx]  <= i_disp_prs1_rdy | w_disp_wake1;
        r_rdy2[w_free_idx]  <= i_disp_prs2_rdy | w_disp_wake2;
        r_prd[w_free_idx]   <= i_disp_prd;
        r_prdv[w_free_idx]  <= i_disp_prdv;
        r_age[w_free_idx]   <= '0;
      end
    end
  end

  // Issue registers: one-cycle pulse per selected op; payload holds when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iss_valid <= '0;
      r_iss_op    <= '0;
      r_iss_prs1  <= '0;
      r_iss_prs2  <= '0;
      r_iss_prd   <= '0;
      r_iss_prdv  <= '0;
    end else if (i_flush) begin
      r_iss_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_iss_valid[p] <= w_sel_vld[p];
        if (w_sel_vld[p]) begin
          r_iss_op[p*OPCODE_WIDTH +: OPCODE_WIDTH] <= r_op[w_sel_idx[p]];
          r_iss_prs1[p*PRF_WIDTH +: PRF_WIDTH]     <= r_prs1[w_sel_idx[p]];
          r_iss_prs2[p*PRF_WIDTH +: PRF_WIDTH]     <= r_prs2[w_sel_idx[p]];
          r_iss_prd[p*PRF_WIDTH +: PRF_WIDTH]      <= r_prd[w_sel_idx[p]];
          r_iss_prdv[p]                            <= r_prdv[w_sel_idx[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios then random traffic, all against a slot-array model.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [6:0]  disp_op;
  logic [1:0]  disp_class;
  logic [5:0]  disp_prs1, disp_prs2, disp_prd;
  logic        disp_prs1_rdy, disp_prs2_rdy, disp_prdv;
  logic [1:0]  wk_valid;
  logic [11:0] wk_tag;
  logic [3:0]  fu_ready;
  logic [3:0]  iss_valid;
  logic [27:0] iss_op;
  logic [23:0] iss_prs1, iss_prs2, iss_prd;
  logic [3:0]  iss_prdv;

  always #5 clk = ~clk;

  issue_queue #(
    .DEPTH(16), .PRF_WIDTH(6), .OPCODE_WIDTH(7), .AGE_WIDTH(5), .NUM_PORTS(4),
    .PORT_CLASS({2'd2, 2'd1, 2'd0, 2'd0}), .NUM_WAKEUP(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_disp_valid(disp_valid),
    .o_disp_ready(disp_ready), .i_disp_op(disp_op), .i_disp_class(disp_class),
    .i_disp_prs1(disp_prs1), .i_disp_prs2(disp_prs2), .i_disp_prs1_rdy(disp_prs1_rdy),
    .i_disp_prs2_rdy(disp_prs2_rdy), .i_disp_prd(disp_prd), .i_disp_prdv(disp_prdv),
    .i_wk_valid(wk_valid), .i_wk_tag(wk_tag), .i_fu_ready(fu_ready),
    .o_iss_valid(iss_valid), .o_iss_op(iss_op), .o_iss_prs1(iss_prs1),
    .o_iss_prs2(iss_prs2), .o_iss_prd(iss_prd), .o_iss_prdv(iss_prdv)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one record per queue slot.
  typedef struct {
    bit         v;
    logic [1:0] cls;
    logic [6:0] op;
    logic [5:0] s1, s2, d;
    bit         r1, r2, dv;
    int         age;
  } ent_t;

  ent_t       m [16];
  int         port_cls [4] = '{0, 0, 1, 2};
  logic [3:0] e_valid;
  logic       e_rdy;
  logic [6:0] e_op [4];
  logic [5:0] e_s1 [4];
  logic [5:0] e_s2 [4];
  logic [5:0] e_d  [4];
  logic       e_dv [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit wk_hit(input logic [5:0] t);
    for (int w = 0; w < 2; w++) begin
      if (wk_valid[w] && (wk_tag[w*6 +: 6] == t)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 16; e++) begin
      m[e].v = 1'b0;
      m[e].age = 0;
    end
    e_valid = '0;
    e_rdy = 1'b1;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit taken [16];
    int best;
    int fidx;
    if (flush) begin
      for (int e = 0; e < 16; e++) m[e].v = 1'b0;
      e_valid = '0;
      e_rdy = 1'b1;
      return;
    end
    for (int e = 0; e < 16; e++) taken[e] = 1'b0;
    for (int p = 0; p < 4; p++) begin
      e_valid[p] = 1'b0;
      if (!fu_ready[p]) continue;
      best = -1;
      for (int e = 0; e < 16; e++) begin
        if (m[e].v && m[e].r1 && m[e].r2 && int'(m[e].cls) == port_cls[p] && !taken[e] &&
            (best < 0 || m[e].age > m[best].age)) best = e;
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        e_valid[p] = 1'b1;
        e_op[p] = m[best].op;
        e_s1[p] = m[best].s1;
        e_s2[p] = m[best].s2;
        e_d[p]  = m[best].d;
        e_dv[p] = m[best].dv;
      end
    end
    fidx = -1;
    for (int e = 0; e < 16; e++) if (!m[e].v && fidx < 0) fidx = e;
    for (int e = 0; e < 16; e++) begin
      if (m[e].v) begin
        if (taken[e]) m[e].v = 1'b0;
        else begin
          if (m[e].age < 31) m[e].age++;
          if (wk_hit(m[e].s1)) m[e].r1 = 1'b1;
          if (wk_hit(m[e].s2)) m[e].r2 = 1'b1;
        end
      end
    end
    if (disp_valid && fidx >= 0) begin
      m[fidx].v   = 1'b1;
      m[fidx].cls = disp_class;
      m[fidx].op  = disp_op;
      m[fidx].s1  = disp_prs1;
      m[fidx].s2  = disp_prs2;
      m[fidx].r1  = disp_prs1_rdy | wk_hit(disp_prs1);
      m[fidx].r2  = disp_prs2_rdy | wk_hit(disp_prs2);
      m[fidx].d   = disp_prd;
      m[fidx].dv  = disp_prdv;
      m[fidx].age = 0;
    end
    e_rdy = 1'b0;
    for (int e = 0; e < 16; e++) if (!m[e].v) e_rdy = 1'b1;
  endtask

  task automatic compare();
    check("disp_ready", disp_ready, e_rdy);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("iss_valid[%0d]", p), iss_valid[p], e_valid[p]);
      if (e_valid[p]) begin
        check($sformatf("iss_op[%0d]", p), iss_op[p*7 +: 7], e_op[p]);
        check($sformatf("iss_prs1[%0d]", p), iss_prs1[p*6 +: 6], e_s1[p]);
        check($sformatf("iss_prs2[%0d]", p), iss_prs2[p*6 +: 6], e_s2[p]);
        check($sformatf("iss_prd[%0d]", p), iss_prd[p*6 +: 6], e_d[p]);
        check($sformatf("iss_prdv[%0d]", p), iss_prdv[p], e_dv[p]);
      end
    end
  endtask

  // Inputs are stable here (driven 1 time unit after the previous edge).
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    disp_valid = 1'b0;
    disp_op = '0;
    disp_class = '0;
    disp_prs1 = '0;
    disp_prs2 = '0;
    disp_prs1_rdy = 1'b0;
    disp_prs2_rdy = 1'b0;
    disp_prd = '0;
    disp_prdv = 1'b0;
    wk_valid = '0;
    wk_tag = '0;
    fu_ready = 4'hF;
  endtask

  task automatic disp(input logic [6:0] op, input logic [1:0] cls, input logic [5:0] s1,
                      input logic r1, input logic [5:0] s2, input logic r2,
                      input logic [5:0] d, input logic dv);
    disp_valid = 1'b1;
    disp_op = op;
    disp_class = cls;
    disp_prs1 = s1;
    disp_prs1_rdy = r1;
    disp_prs2 = s2;
    disp_prs2_rdy = r2;
    disp_prd = d;
    disp_prdv = dv;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_iss_valid", iss_valid, 0);
    check("rst_iss_op", iss_op, 0);
    check("rst_iss_prd", iss_prd, 0);
    check("rst_iss_prs1", iss_prs1, 0);
    check("rst_disp_ready", disp_ready, 1);
    rst = 1'b0;

    // Single ready ALU op: issue two cycles after dispatch on port 0.
    disp(7'h13, 2'd0, 6'd3, 1'b1, 6'd4, 1'b1, 6'd9, 1'b1);
    cyc();
    idle_inputs();
    cyc();
    check("t1_valid0", iss_valid[0], 1);
    check("t1_prd", iss_prd[5:0], 9);
    check("t1_port1_idle", iss_valid[1], 0);
    cyc();

    // Wakeup three cycles after dispatch; issue exactly two cycles after wakeup.
    disp(7'h21, 2'd0, 6'd5, 1'b0, 6'd6, 1'b1, 6'd10, 1'b1);
    cyc();
    idle_inputs();
    cyc();
    cyc();
    wk_valid = 2'b01;
    wk_tag = {6'd0, 6'd5};
    cyc();
    check("t2_not_early", iss_valid[0], 0);
    idle_inputs();
    cyc();
    check("t2_issue", iss_valid[0], 1);
    check("t2_prd", iss_prd[5:0], 10);
    cyc();

    // Two ALU ops held back, then released together onto ports 0 and 1.
    fu_ready = 4'b1100;
    disp(7'h01, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd11, 1'b1);
    cyc();
    disp(7'h02, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd12, 1'b0);
    cyc();
    idle_inputs();
    cyc();
    check("t3_both", iss_valid[1:0], 2'b11);
    check("t3_a_p0", iss_prd[5:0], 11);
    check("t3_b_p1", iss_prd[11:6], 12);
    fu_ready = 4'b1100;
    disp(7'h03, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd13, 1'b1);
    cyc();
    disp(7'h04, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd14, 1'b1);
    cyc();
    idle_inputs();
    fu_ready = 4'b1110;
    cyc();
    check("t3_a_p1", iss_valid[1:0], 2'b10);
    check("t3_a_prd", iss_prd[11:6], 13);
    cyc();
    check("t3_b_next", iss_valid[1], 1);
    check("t3_b_prd", iss_prd[11:6], 14);
    idle_inputs();
    cyc();

    // Fill with waiting MUL ops, push against backpressure, let ages saturate.
    for (int i = 0; i < 16; i++) begin
      disp(7'(7'h40 + i), 2'd1, 6'(16 + i), 1'b0, 6'd0, 1'b1, 6'(i + 1), 1'b1);
      cyc();
    end
    check("t4_full", disp_ready, 0);
    idle_inputs();
    disp(7'h7F, 2'd1, 6'd1, 1'b1, 6'd1, 1'b1, 6'd50, 1'b1);
    cyc();
    idle_inputs();
    repeat (35) cyc();
    wk_valid = 2'b11;
    wk_tag = {6'd26, 6'd19};
    cyc();
    idle_inputs();
    cyc();
    check("t4_mul_p2", iss_valid[2], 1);
    check("t4_sat_tie_low", iss_prd[17:12], 4);
    check("t4_ready_back", disp_ready, 1);
    cyc();
    check("t4_second", iss_prd[17:12], 11);
    flush = 1'b1;
    cyc();
    idle_inputs();

    // Source woken by a wakeup in its own dispatch cycle.
    disp(7'h55, 2'd2, 6'd33, 1'b0, 6'd34, 1'b1, 6'd20, 1'b1);
    wk_valid = 2'b01;
    wk_tag = {6'd0, 6'd33};
    cyc();
    idle_inputs();
    cyc();
    check("t5_ls_issue", iss_valid[3], 1);
    check("t5_prd", iss_prd[23:18], 20);
    cyc();

    // Flush with five waiting entries and a concurrent dispatch.
    for (int i = 0; i < 5; i++) begin
      disp(7'(7'h60 + i), 2'd0, 6'd40, 1'b0, 6'd41, 1'b1, 6'(30 + i), 1'b1);
      cyc();
    end
    disp(7'h66, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd45, 1'b1);
    flush = 1'b1;
    cyc();
    check("t6_iss_clear", iss_valid, 0);
    check("t6_ready", disp_ready, 1);
    idle_inputs();
    wk_valid = 2'b10;
    wk_tag = {6'd40, 6'd0};
    cyc();
    idle_inputs();
    cyc();
    cyc();
    check("t6_nothing_left", iss_valid, 0);

    // Asynchronous reset while an issue pulse is being presented.
    disp(7'h11, 2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd7, 1'b1);
    cyc();
    idle_inputs();
    cyc();
    #3;
    rst = 1'b1;
    #1;
    check("arst_iss_valid", iss_valid, 0);
    check("arst_iss_prd", iss_prd, 0);
    check("arst_ready", disp_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      idle_inputs();
      disp_valid = 1'($urandom_range(0, 1));
      disp_class = 2'($urandom_range(0, 2));
      disp_op = 7'($urandom);
      disp_prs1 = 6'($urandom_range(0, 15));
      disp_prs2 = 6'($urandom_range(0, 15));
      disp_prs1_rdy = ($urandom_range(0, 2) != 0);
      disp_prs2_rdy = ($urandom_range(0, 2) != 0);
      disp_prd = 6'($urandom);
      disp_prdv = 1'($urandom_range(0, 1));
      wk_valid = 2'($urandom_range(0, 3));
      wk_tag = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      fu_ready = 4'($urandom) | 4'($urandom);
      flush = ($urandom_range(0, 59) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
